// File: rtl/instruction_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit_if
//
// Groups the buses of the RV32I fetch stage:
//   imem request   : imem_req_valid / imem_req_ready / imem_addr
//   imem response  : imem_resp_valid / imem_resp_data (in order, no backpressure)
//   decode         : instr_valid / instr_ready / instr / instr_pc
//   redirect       : redirect_valid / redirect_pc (from execute)
//   status         : fetch_misaligned
// Modports:
//   master - the fetch unit itself
//   slave  - memory, decode and execute as seen from the fetch unit
// ---------------------------------------------------------------------------
interface instruction_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_misaligned;

  modport master (
    output imem_req_valid, imem_addr,
    input  imem_req_ready,
    input  imem_resp_valid, imem_resp_data,
    output instr_valid, instr, instr_pc,
    input  instr_ready,
    input  redirect_valid, redirect_pc,
    output fetch_misaligned
  );

  modport slave (
    input  imem_req_valid, imem_addr,
    output imem_req_ready,
    output imem_resp_valid, imem_resp_data,
    input  instr_valid, instr, instr_pc,
    output instr_ready,
    output redirect_valid, redirect_pc,
    input  fetch_misaligned
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// RV32I fetch stage. Holds the PC, issues word requests to instruction
// memory, tags each request with its PC and buffers returned words in a small
// in-order queue presented to decode with a valid/ready handshake. Redirects
// from execute flush the queue; responses still in flight for the old path
// are counted off and discarded.
//
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous, active-high reset
//   bus  - instruction_fetch_unit_if.master (imem, decode, redirect, status)
//
// Parameters:
//   RESET_PC - PC loaded on reset
//   IQ_DEPTH - queue entries (power of two, >= 2); also bounds
//              outstanding requests + queued entries
//
// Optional feature (macro IFU_MISALIGN_CHECK_EN):
//   defined   - a redirect with redirect_pc[1:0] != 0 halts fetch and raises
//               fetch_misaligned until reset or the next aligned redirect
//   undefined - redirect_pc[1:0] is forced to 2'b00, fetch_misaligned is 0
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IQ_DEPTH = 2
) (
  input logic                      clk,
  input logic                      rst,
  instruction_fetch_unit_if.master bus
);

  localparam int AW = $clog2(IQ_DEPTH);
  localparam int CW = $clog2(IQ_DEPTH + 1);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;
  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } iq_entry_t;

  localparam cnt_t         CNT_FULL = cnt_t'(IQ_DEPTH);
  localparam logic [CW:0]  CREDITS  = (CW + 1)'(IQ_DEPTH);

  logic [31:0] pc_q, pc_d;
  cnt_t        outstanding_q, outstanding_d;
  cnt_t        drop_q, drop_d;
  cnt_t        iq_count_q, iq_count_d;
  ptr_t        iq_rd_q, iq_wr_q;
  ptr_t        tag_rd_q, tag_wr_q;
  logic        halted_q, halted_d;
  iq_entry_t   iq_q  [IQ_DEPTH];
  logic [31:0] tag_q [IQ_DEPTH];

  logic        redirect;
  logic [31:0] redirect_target;
  logic        redirect_misaligned;
  logic [CW:0] credits_used;
  logic        req_valid, req_fire;
  logic        resp;
  logic        iq_push, iq_pop;
  logic        instr_valid;

  assign redirect        = bus.redirect_valid;
  assign redirect_target = {bus.redirect_pc[31:2], 2'b00};

`ifdef IFU_MISALIGN_CHECK_EN
  assign redirect_misaligned = bus.redirect_pc[1:0] != 2'b00;
`else
  logic unused_redirect_low;
  assign unused_redirect_low = ^bus.redirect_pc[1:0];
  assign redirect_misaligned = 1'b0;
`endif

  // Requests in flight (including ones that will be dropped) plus queued
  // words may never exceed the queue depth, so a response always has room.
  assign credits_used = {1'b0, outstanding_q} + {1'b0, iq_count_q};
  assign req_valid    = !rst && !redirect && !halted_q && (credits_used < CREDITS);
  assign req_fire     = req_valid && bus.imem_req_ready;

  assign resp        = bus.imem_resp_valid;
  assign iq_push     = resp && (drop_q == '0) && !redirect;
  assign instr_valid = (iq_count_q != '0) && !redirect;
  assign iq_pop      = instr_valid && bus.instr_ready;

  always_comb begin
    // NOTE: every always_comb target gets its default first, so no path can leave it unassigned and infer a latch.
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    iq_count_d    = iq_count_q;
    halted_d      = halted_q;

    // Outstanding tracks every request until its response returns,
    // whether that response is kept or discarded.
    if (req_fire && !resp)      outstanding_d = outstanding_q + cnt_t'(1);
    else if (!req_fire && resp) outstanding_d = outstanding_q - cnt_t'(1);

    if (redirect) begin
      pc_d       = redirect_target;
      iq_count_d = '0;
      halted_d   = redirect_misaligned;
      // Everything still in flight after this cycle belongs to the old path;
      // a response arriving right now is discarded directly.
      drop_d     = resp ? outstanding_q - cnt_t'(1) : outstanding_q;
    end else begin
      if (req_fire) pc_d = pc_q + 32'd4;
      if (resp && drop_q != '0) drop_d = drop_q - cnt_t'(1);
      if (iq_push && !iq_pop)      iq_count_d = iq_count_q + cnt_t'(1);
      else if (iq_pop && !iq_push) iq_count_d = iq_count_q - cnt_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, regardless of statement order.
    if (rst) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      iq_count_q    <= '0;
      halted_q      <= 1'b0;
      iq_rd_q       <= '0;
      iq_wr_q       <= '0;
      tag_rd_q      <= '0;
      tag_wr_q      <= '0;
      // NOTE: queue storage is reset because its head drives instr/instr_pc directly; the tag storage below never reaches an output unwritten, so it has no reset.
      for (int i = 0; i < IQ_DEPTH; i++) iq_q[i] <= '0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      iq_count_q    <= iq_count_d;
      halted_q      <= halted_d;

      // The tag FIFO is never flushed: dropped responses still retire their tags.
      if (req_fire) tag_wr_q <= tag_wr_q + ptr_t'(1);
      if (resp)     tag_rd_q <= tag_rd_q + ptr_t'(1);

      if (redirect) begin
        iq_rd_q <= '0;
        iq_wr_q <= '0;
      end else begin
        if (iq_pop) iq_rd_q <= iq_rd_q + ptr_t'(1);
        if (iq_push) begin
          iq_q[iq_wr_q] <= {bus.imem_resp_data, tag_q[tag_rd_q]};
          iq_wr_q       <= iq_wr_q + ptr_t'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) tag_q[tag_wr_q] <= pc_q;
  end

  assign bus.imem_req_valid   = req_valid;
  assign bus.imem_addr        = pc_q;
  assign bus.instr_valid      = instr_valid;
  assign bus.instr            = iq_q[iq_rd_q].data;
  assign bus.instr_pc         = iq_q[iq_rd_q].pc;
  assign bus.fetch_misaligned = halted_q;

  // The credit rule makes a push into a full queue impossible.
  assert property (@(posedge clk) disable iff (rst) !(iq_push && iq_count_q == CNT_FULL));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Drives instruction_fetch_unit through its interface with a behavioural
// memory (configurable latency, random acceptance) and decode (random
// ready). A scoreboard predicts the request stream, credit limit and
// delivered {instr_pc, instr} pairs: requests carry a path epoch and only
// current-path words are expected at decode.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  localparam int          IQ_DEPTH = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mem_req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } iq_model_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  instruction_fetch_unit_if bus_if ();

  instruction_fetch_unit #(
    .RESET_PC (RESET_PC),
    .IQ_DEPTH (IQ_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard state
  mem_req_t    mem_q[$];
  iq_model_t   iq_m[$];
  logic [31:0] pc_exp     = RESET_PC;
  int          epoch      = 0;
  bit          halted_exp = 1'b0;
  int          cyc        = 0;
  int          last_due   = -1;

  // Stimulus knobs
  int lat          = 1;
  int req_rdy_pct  = 100;
  int ir_pct       = 100;
  int redir_permil = 0;

  // Observation helpers for directed checks
  int          first_iv     = -1;
  int          dut_req_cnt  = 0;
  bit          watch_pc     = 1'b0;
  logic [31:0] watched_pc   = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // One clock cycle. Entered just after a falling edge; drives inputs,
  // checks outputs against the scoreboard, advances the scoreboard, then
  // waits through the rising edge to the next falling edge.
  task automatic step(input bit force_redir = 1'b0, input logic [31:0] force_pc = '0);
    bit          resp_v, redir, req_rdy, ir;
    bit          exp_rv, exp_iv;
    logic [31:0] rpc;
    mem_req_t    m;

    resp_v  = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    req_rdy = ($urandom_range(99) < req_rdy_pct);
    ir      = ($urandom_range(99) < ir_pct);
    redir   = force_redir || ($urandom_range(999) < redir_permil);
    if (force_redir) rpc = force_pc;
    else begin
      rpc = $urandom & 32'h0000_0FFC;
      if ($urandom_range(7) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(15) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
    end

    rst                    = 1'b0;
    bus_if.imem_resp_valid = resp_v;
    bus_if.imem_resp_data  = resp_v ? word_of(mem_q[0].addr) : $urandom;
    bus_if.imem_req_ready  = req_rdy;
    bus_if.instr_ready     = ir;
    bus_if.redirect_valid  = redir;
    bus_if.redirect_pc     = rpc;
    #1;

    exp_rv = !redir && !halted_exp && (mem_q.size() + iq_m.size() < IQ_DEPTH);
    exp_iv = (iq_m.size() > 0) && !redir;

    check("imem_req_valid", 32'(bus_if.imem_req_valid), 32'(exp_rv));
    if (exp_rv) check("imem_addr", bus_if.imem_addr, pc_exp);
    check("instr_valid", 32'(bus_if.instr_valid), 32'(exp_iv));
    if (exp_iv) begin
      check("instr_pc", bus_if.instr_pc, iq_m[0].pc);
      check("instr", bus_if.instr, iq_m[0].data);
    end
    check("fetch_misaligned", 32'(bus_if.fetch_misaligned), 32'(halted_exp));

    // Observations of the DUT used by directed checks only
    if (bus_if.instr_valid && first_iv < 0) first_iv = cyc;
    if (bus_if.imem_req_valid && req_rdy) dut_req_cnt++;
    if (watch_pc && bus_if.instr_valid && ir) begin
      watched_pc = bus_if.instr_pc;
      watch_pc   = 1'b0;
    end

    // Scoreboard update for the coming edge
    if (resp_v) begin
      m = mem_q.pop_front();
      if (!redir && m.epoch == epoch) iq_m.push_back('{pc: m.addr, data: word_of(m.addr)});
    end
    if (exp_iv && ir) void'(iq_m.pop_front());
    if (exp_rv && req_rdy) begin
      m.addr  = pc_exp;
      m.epoch = epoch;
      m.due   = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      last_due = m.due;
      mem_q.push_back(m);
      pc_exp = pc_exp + 32'd4;
    end
    if (redir) begin
      iq_m.delete();
      epoch++;
      pc_exp = {rpc[31:2], 2'b00};
`ifdef IFU_MISALIGN_CHECK_EN
      halted_exp = (rpc[1:0] != 2'b00);
`else
      halted_exp = 1'b0;
`endif
    end

    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    bus_if.imem_req_ready  = 1'b0;
    bus_if.imem_resp_valid = 1'b0;
    bus_if.imem_resp_data  = '0;
    bus_if.instr_ready     = 1'b0;
    bus_if.redirect_valid  = 1'b0;
    bus_if.redirect_pc     = '0;

    // Reset: outputs quiet while rst is held
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_valid", 32'(bus_if.imem_req_valid), 32'd0);
    check("rst_instr_valid", 32'(bus_if.instr_valid), 32'd0);
    check("rst_instr", bus_if.instr, 32'd0);
    check("rst_instr_pc", bus_if.instr_pc, 32'd0);
    check("rst_misaligned", 32'(bus_if.fetch_misaligned), 32'd0);
    check("rst_imem_addr", bus_if.imem_addr, RESET_PC);
    @(negedge clk);

    // Straight-line fetch with 1-cycle memory
    repeat (8) step();
    check("first_iv_latency", first_iv, 32'd2);

    // Decode stall: only IQ_DEPTH requests accepted, then resume in order
    step(1'b1, 32'h0000_0000);
    ir_pct      = 0;
    dut_req_cnt = 0;
    repeat (10) step();
    check("stall_reqs", dut_req_cnt, IQ_DEPTH);
    ir_pct = 100;
    repeat (6) step();

    // 3-cycle memory, redirect with two requests outstanding
    lat = 3;
    step(1'b1, 32'h0000_0000);
    repeat (2) step();
    step(1'b1, 32'h0000_0100);
    watch_pc = 1'b1;
    repeat (10) step();
    check("redir_first_pc", watched_pc, 32'h0000_0100);

    // Redirect colliding with a response and a ready decode
    lat = 1;
    repeat (6) step();
    step(1'b1, 32'h0000_0040);
    watch_pc = 1'b1;
    repeat (6) step();
    check("collide_first_pc", watched_pc, 32'h0000_0040);

    // PC wrap
    step(1'b1, 32'hFFFF_FFF8);
    repeat (8) step();

    // Misaligned redirect, then aligned redirect
    step(1'b1, 32'h0000_0102);
    watch_pc = 1'b1;
    repeat (6) step();
`ifdef IFU_MISALIGN_CHECK_EN
    check("halted_flag", 32'(bus_if.fetch_misaligned), 32'd1);
`else
    check("masked_first_pc", watched_pc, 32'h0000_0100);
`endif
    step(1'b1, 32'h0000_0200);
    watch_pc = 1'b1;
    repeat (6) step();
    check("realign_first_pc", watched_pc, 32'h0000_0200);

    // Randomised traffic
    for (int ph = 0; ph < 8; ph++) begin
      lat          = $urandom_range(1, 4);
      req_rdy_pct  = $urandom_range(40, 100);
      ir_pct       = $urandom_range(30, 100);
      redir_permil = $urandom_range(10, 60);
      repeat (500) step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
